// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_pkg
//  Description : Shared opcode codes, decoded-op enum, decode struct and
//                pipeline state encoding for the accumulator pipeline core.
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

  // 8-bit opcode codes; the low byte of every instruction word
  localparam logic [7:0] c_op_nop  = 8'h00;
  localparam logic [7:0] c_op_add  = 8'h01;
  localparam logic [7:0] c_op_sub  = 8'h02;
  localparam logic [7:0] c_op_brnz = 8'h03;
  localparam logic [7:0] c_op_st   = 8'h04;
  localparam logic [7:0] c_op_ld   = 8'h05;
  localparam logic [7:0] c_op_ldi  = 8'h06;
  localparam logic [7:0] c_op_exit = 8'h07;
  localparam logic [7:0] c_op_and  = 8'h08;
  localparam logic [7:0] c_op_or   = 8'h09;
  localparam logic [7:0] c_op_xor  = 8'h0A;
  localparam logic [7:0] c_op_brz  = 8'h0B;
  localparam logic [7:0] c_op_brc  = 8'h0C;
  localparam logic [7:0] c_op_jmp  = 8'h0D;

  typedef enum logic [3:0] {
    OP_NOP  = 4'd0,
    OP_LDI  = 4'd1,
    OP_ADD  = 4'd2,
    OP_SUB  = 4'd3,
    OP_AND  = 4'd4,
    OP_OR   = 4'd5,
    OP_XOR  = 4'd6,
    OP_LD   = 4'd7,
    OP_ST   = 4'd8,
    OP_BRNZ = 4'd9,
    OP_BRZ  = 4'd10,
    OP_BRC  = 4'd11,
    OP_JMP  = 4'd12,
    OP_EXIT = 4'd13
  } op_e;

  // Decoded instruction as carried into EX; illegal opcodes decode to NOP
  typedef struct packed {
    op_e  op;
    logic illegal;
  } dec_t;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_LDWAIT = 2'd1,
    ST_HALT   = 2'd2
  } state_e;

endpackage
`default_nettype wire

// File: rtl/acc_pipe_decode.sv
`default_nettype none
// ============================================================================
//  Module      : acc_pipe_decode
//  Description : Pure combinational opcode decoder for the ID stage.
//  Revision    : 1.0 - initial release
// ============================================================================
module acc_pipe_decode
  import cpu_pkg::*;
(
  input  logic [7:0] i_opcode,
  output dec_t       o_dec
);

  // Map the 8-bit opcode onto the internal op; unknown codes become flagged NOPs
  always_comb begin
    o_dec.op      = OP_NOP;
    o_dec.illegal = 1'b0;
    case (i_opcode)
      c_op_nop:  o_dec.op = OP_NOP;
      c_op_ldi:  o_dec.op = OP_LDI;
      c_op_add:  o_dec.op = OP_ADD;
      c_op_sub:  o_dec.op = OP_SUB;
      c_op_and:  o_dec.op = OP_AND;
      c_op_or:   o_dec.op = OP_OR;
      c_op_xor:  o_dec.op = OP_XOR;
      c_op_ld:   o_dec.op = OP_LD;
      c_op_st:   o_dec.op = OP_ST;
      c_op_brnz: o_dec.op = OP_BRNZ;
      c_op_brz:  o_dec.op = OP_BRZ;
      c_op_brc:  o_dec.op = OP_BRC;
      c_op_jmp:  o_dec.op = OP_JMP;
      c_op_exit: o_dec.op = OP_EXIT;
      default:   o_dec.illegal = 1'b1;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/acc_pipe_core.sv
`default_nettype none
// ============================================================================
//  Module      : acc_pipe_core
//  Description : 3-stage (IF/ID/EX) accumulator core with sync-SRAM imem and
//                dmem ports, carry flag, branches, run-enable pause, sticky
//                exit/illegal flags and a one-cycle load stall.
//  Revision    : 1.0 - initial release
// ============================================================================
module acc_pipe_core
  import cpu_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8,
  parameter int RST_PC = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run_en,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [ADDR_W+7:0] imem_rdata,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  output logic              dmem_we,
  output logic              dmem_re,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic [ADDR_W-1:0] io_pc,
  output logic [DATA_W-1:0] io_out,
  output logic              io_carry,
  output logic              io_exit,
  output logic              io_illegal
);

  state_e              r_state;
  logic [ADDR_W-1:0]   r_pc;
  logic                r_id_valid;
  logic [ADDR_W-1:0]   r_id_pc;
  logic                r_hold_valid;
  logic [ADDR_W+7:0]   r_hold_instr;
  logic                r_ex_valid;
  dec_t                r_ex_dec;
  logic [ADDR_W-1:0]   r_ex_opr;
  logic [ADDR_W-1:0]   r_ex_pc;
  logic [DATA_W-1:0]   r_accu;
  logic                r_carry;
  logic                r_exit;
  logic                r_illegal;

  logic [ADDR_W+7:0]   w_id_instr;
  dec_t                w_id_dec;
  logic                w_exec;
  logic                w_take;
  logic                w_adv;
  logic [DATA_W-1:0]   w_imm;
  logic [DATA_W:0]     w_sum;
  logic [DATA_W:0]     w_diff;

  // While the pipeline is stalled the SRAM keeps re-reading the held pc, so the
  // word belonging to the ID instruction is parked in r_hold_instr until ID moves.
  assign w_id_instr = r_hold_valid ? r_hold_instr : imem_rdata;

  acc_pipe_decode u_decode (
    .i_opcode (w_id_instr[7:0]),
    .o_dec    (w_id_dec)
  );

  assign w_exec = run_en && (r_state == ST_RUN) && r_ex_valid;
  assign w_imm  = DATA_W'(r_ex_opr);
  assign w_sum  = {1'b0, r_accu} + {1'b0, w_imm};
  assign w_diff = {1'b0, r_accu} - {1'b0, w_imm};
  assign w_adv  = run_en && (r_state == ST_RUN) && !(w_exec && (r_ex_dec.op == OP_EXIT));

  // Branch resolution for the instruction currently in EX
  always_comb begin
    w_take = 1'b0;
    if (w_exec) begin
      case (r_ex_dec.op)
        OP_BRNZ: w_take = (r_accu != '0);
        OP_BRZ:  w_take = (r_accu == '0);
        OP_BRC:  w_take = r_carry;
        OP_JMP:  w_take = 1'b1;
        default: w_take = 1'b0;
      endcase
    end
  end

  // Pipeline advance, execute stage and RUN/LDWAIT/HALT control
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state         <= ST_RUN;
      r_pc            <= ADDR_W'(RST_PC);
      r_id_valid      <= 1'b0;
      r_id_pc         <= '0;
      r_hold_valid    <= 1'b0;
      r_hold_instr    <= '0;
      r_ex_valid      <= 1'b0;
      r_ex_dec.op     <= OP_NOP;
      r_ex_dec.illegal <= 1'b0;
      r_ex_opr        <= '0;
      r_ex_pc         <= '0;
      r_accu          <= '0;
      r_carry         <= 1'b0;
      r_exit          <= 1'b0;
      r_illegal       <= 1'b0;
    end else begin
      if (w_adv) begin
        r_hold_valid <= 1'b0;
      end else if (!r_hold_valid) begin
        r_hold_valid <= 1'b1;
        r_hold_instr <= imem_rdata;
      end

      if (w_adv) begin
        r_pc       <= w_take ? r_ex_opr : r_pc + 1'b1;
        r_id_valid <= !w_take;
        r_id_pc    <= r_pc;
        r_ex_valid <= r_id_valid && !w_take;
        r_ex_dec   <= w_id_dec;
        r_ex_opr   <= w_id_instr[ADDR_W+7:8];
        r_ex_pc    <= r_id_pc;
      end

      if (w_exec) begin
        if (r_ex_dec.illegal) begin
          r_illegal <= 1'b1;
        end
        case (r_ex_dec.op)
          OP_LDI:  r_accu <= w_imm;
          OP_ADD:  {r_carry, r_accu} <= w_sum;
          OP_SUB:  {r_carry, r_accu} <= w_diff;
          OP_AND:  r_accu <= r_accu & w_imm;
          OP_OR:   r_accu <= r_accu | w_imm;
          OP_XOR:  r_accu <= r_accu ^ w_imm;
          OP_LD:   r_state <= ST_LDWAIT;
          OP_EXIT: begin
            r_exit  <= 1'b1;
            r_state <= ST_HALT;
          end
          default: ;
        endcase
      end

      if (run_en && (r_state == ST_LDWAIT)) begin
        r_accu  <= dmem_rdata;
        r_state <= ST_RUN;
      end
    end
  end

  assign imem_addr  = r_pc;
  assign dmem_addr  = r_ex_opr;
  assign dmem_wdata = r_accu;
  assign dmem_we    = w_exec && (r_ex_dec.op == OP_ST);
  assign dmem_re    = w_exec && (r_ex_dec.op == OP_LD);
  assign io_pc      = r_ex_pc;
  assign io_out     = r_accu;
  assign io_carry   = r_carry;
  assign io_exit    = r_exit;
  assign io_illegal = r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_acc_pipe_core.sv
`default_nettype none
// ============================================================================
//  Module      : tb_acc_pipe_core
//  Description : Self-checking bench for acc_pipe_core against an
//                instruction-level reference model with cycle accounting.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_acc_pipe_core;
  import cpu_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        run_en;
  logic [7:0]  imem_addr;
  logic [15:0] imem_rdata;
  logic [7:0]  dmem_addr;
  logic [15:0] dmem_wdata;
  logic        dmem_we;
  logic        dmem_re;
  logic [15:0] dmem_rdata;
  logic [7:0]  io_pc;
  logic [15:0] io_out;
  logic        io_carry;
  logic        io_exit;
  logic        io_illegal;

  acc_pipe_core #(.DATA_W(16), .ADDR_W(8), .RST_PC(0)) dut (
    .clk(clk), .rst_n(rst_n), .run_en(run_en),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_we(dmem_we),
    .dmem_re(dmem_re), .dmem_rdata(dmem_rdata),
    .io_pc(io_pc), .io_out(io_out), .io_carry(io_carry),
    .io_exit(io_exit), .io_illegal(io_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Program and data memories (sync-read SRAMs, dout held when not reading)
  logic [15:0] prog   [256];
  logic [15:0] sram_d [256];

  always @(posedge clk) begin
    imem_rdata <= prog[imem_addr];
    if (dmem_we) sram_d[dmem_addr] <= dmem_wdata;
    if (dmem_re) dmem_rdata <= sram_d[dmem_addr];
  end

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [15:0] m_dmem [256];
  logic [15:0] m_accu;
  bit          m_carry;
  bit          m_ill;
  bit          m_done;
  int          m_exit_pc;
  int          m_cycles;
  logic [7:0]  m_st_addr [$];
  logic [15:0] m_st_data [$];

  // Executes the program instruction by instruction; m_cycles tracks the EX
  // cycle of the current instruction (first one at cycle 2, +2 per taken
  // branch, +1 per load).
  task automatic run_model();
    int pc, steps, r;
    logic [7:0]  op;
    logic [15:0] imm;
    bit take;
    pc = 0; steps = 0; m_accu = 0; m_carry = 0; m_ill = 0; m_done = 0;
    m_exit_pc = 0; m_cycles = 2;
    m_st_addr.delete(); m_st_data.delete();
    while (!m_done && steps < 5000) begin
      op = prog[pc][7:0];
      imm = 16'(prog[pc][15:8]);
      take = 0;
      steps++;
      case (op)
        c_op_nop:  ;
        c_op_ldi:  m_accu = imm;
        c_op_add:  begin r = int'(m_accu) + int'(imm); m_carry = (r > 65535); m_accu = 16'(r); end
        c_op_sub:  begin m_carry = (m_accu < imm); m_accu = m_accu - imm; end
        c_op_and:  m_accu = m_accu & imm;
        c_op_or:   m_accu = m_accu | imm;
        c_op_xor:  m_accu = m_accu ^ imm;
        c_op_ld:   begin m_accu = m_dmem[imm[7:0]]; m_cycles++; end
        c_op_st:   begin m_dmem[imm[7:0]] = m_accu; m_st_addr.push_back(imm[7:0]); m_st_data.push_back(m_accu); end
        c_op_brnz: take = (m_accu != 0);
        c_op_brz:  take = (m_accu == 0);
        c_op_brc:  take = m_carry;
        c_op_jmp:  take = 1;
        c_op_exit: begin m_done = 1; m_exit_pc = pc; end
        default:   m_ill = 1;
      endcase
      if (!m_done) begin
        m_cycles++;
        if (take) begin m_cycles += 2; pc = int'(imm[7:0]); end
        else pc = (pc + 1) % 256;
      end
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic clear_prog();
    for (int i = 0; i < 256; i++) prog[i] = {8'h00, c_op_exit};
  endtask

  task automatic put(input int a, input logic [7:0] op, input logic [7:0] opr);
    prog[a] = {opr, op};
  endtask

  task automatic init_dmem();
    for (int i = 0; i < 256; i++) begin
      m_dmem[i] = (i < 16) ? 16'($urandom) : 16'h0;
      sram_d[i] = m_dmem[i];
    end
  endtask

  task automatic gen_prog(input int len);
    logic [7:0] ops [15];
    int k;
    ops = '{c_op_ldi, c_op_add, c_op_sub, c_op_and, c_op_or, c_op_xor, c_op_ld,
            c_op_st, c_op_brnz, c_op_brz, c_op_brc, c_op_jmp, c_op_nop, c_op_ld, 8'hEE};
    clear_prog();
    for (int i = 0; i < len - 1; i++) begin
      k = $urandom_range(0, 14);
      if (k == 14 && $urandom_range(0, 2) != 0) k = 7;
      case (ops[k])
        c_op_ld, c_op_st: put(i, ops[k], 8'($urandom_range(0, 15)));
        c_op_brnz, c_op_brz, c_op_brc, c_op_jmp: put(i, ops[k], 8'($urandom_range(i + 1, len - 1)));
        default: put(i, ops[k], 8'($urandom));
      endcase
    end
    put(len - 1, c_op_exit, 8'h00);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    run_en = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  // Runs the loaded program on the DUT and compares against the model
  task automatic run_dut(input bit rnd, input string nm);
    int cyc, n_st_seen, n_st_exp;
    bit seen;
    logic [7:0] exp_if_pc;
    n_st_seen = 0;
    n_st_exp = m_st_addr.size();
    apply_reset();
    check_eq({nm, ":rst_out"},   io_out,     32'h0);
    check_eq({nm, ":rst_carry"}, io_carry,   32'h0);
    check_eq({nm, ":rst_exit"},  io_exit,    32'h0);
    check_eq({nm, ":rst_ill"},   io_illegal, 32'h0);
    check_eq({nm, ":rst_pc"},    imem_addr,  32'h0);
    check_eq({nm, ":rst_strb"},  {dmem_we, dmem_re}, 32'h0);
    cyc = 0;
    seen = 0;
    while (cyc < 4000) begin
      run_en = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      #1;
      if (dmem_we) begin
        n_st_seen++;
        if (m_st_addr.size() > 0) begin
          check_eq({nm, ":st_addr"}, dmem_addr, m_st_addr.pop_front());
          check_eq({nm, ":st_data"}, dmem_wdata, m_st_data.pop_front());
        end
      end
      if (io_exit) begin
        seen = 1;
        break;
      end
      @(negedge clk);
      cyc++;
    end
    check_eq({nm, ":exit_seen"}, seen, 32'h1);
    if (!rnd) check_eq({nm, ":exit_cycle"}, cyc, m_cycles + 1);
    check_eq({nm, ":accu"},    io_out,     m_accu);
    check_eq({nm, ":carry"},   io_carry,   m_carry);
    check_eq({nm, ":illegal"}, io_illegal, m_ill);
    check_eq({nm, ":ex_pc"},   io_pc,      m_exit_pc);
    check_eq({nm, ":st_cnt"},  n_st_seen,  n_st_exp);
    // IF runs two instructions ahead of EX and freezes once EXIT retires
    exp_if_pc = 8'(m_exit_pc + 2);
    run_en = 1'b1;
    repeat (3) begin
      @(negedge clk);
      #1;
      check_eq({nm, ":halt_pc"},   imem_addr, exp_if_pc);
      check_eq({nm, ":halt_strb"}, {dmem_we, dmem_re}, 32'h0);
      check_eq({nm, ":halt_accu"}, io_out, m_accu);
    end
  endtask

  task automatic reset_mid_load();
    int cyc;
    clear_prog();
    put(0, c_op_ldi, 8'h2A); put(1, c_op_st, 8'h10); put(2, c_op_add, 8'h05);
    put(3, c_op_ld, 8'h10);  put(4, c_op_add, 8'h01); put(5, c_op_exit, 8'h00);
    init_dmem();
    apply_reset();
    cyc = 0;
    while (!dmem_re && cyc < 50) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    check_eq("rld:re_seen", dmem_re, 32'h1);
    check_eq("rld:accu_pre", io_out, 32'h2F);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check_eq("rld:out",   io_out,    32'h0);
    check_eq("rld:carry", io_carry,  32'h0);
    check_eq("rld:strb",  {dmem_we, dmem_re}, 32'h0);
    check_eq("rld:pc",    imem_addr, 32'h0);
    check_eq("rld:exit",  io_exit,   32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_eq("rld:no_late_load", io_out, 32'h0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst_n = 1'b0;
    run_en = 1'b0;
    clear_prog();
    for (int i = 0; i < 256; i++) sram_d[i] = 16'h0;

    // Arithmetic with borrow
    clear_prog();
    put(0, c_op_ldi, 8'd5); put(1, c_op_add, 8'd3); put(2, c_op_sub, 8'd10); put(3, c_op_exit, 8'd0);
    init_dmem(); run_model(); run_dut(0, "arith");
    check_eq("arith:const_out", io_out, 32'hFFFE);

    // Countdown loop with backward branch
    for (int r = 0; r < 2; r++) begin
      clear_prog();
      put(0, c_op_ldi, 8'd3); put(1, c_op_sub, 8'd1); put(2, c_op_brnz, 8'd1); put(3, c_op_exit, 8'd0);
      init_dmem(); run_model(); run_dut(r[0], "loop");
      check_eq("loop:const_out", io_out, 32'h0);
    end

    // Store then load-back with stall
    for (int r = 0; r < 2; r++) begin
      clear_prog();
      put(0, c_op_ldi, 8'h2A); put(1, c_op_st, 8'h10); put(2, c_op_ldi, 8'h00);
      put(3, c_op_ld, 8'h10);  put(4, c_op_add, 8'h01); put(5, c_op_exit, 8'h00);
      init_dmem(); run_model(); run_dut(r[0], "ldst");
      check_eq("ldst:const_out", io_out, 32'h2B);
    end

    // Wrap-around carry, BRC taken over a poison LDI, then logic ops
    clear_prog();
    put(0, c_op_ldi, 8'h00); put(1, c_op_sub, 8'h01); put(2, c_op_add, 8'h01);
    put(3, c_op_brc, 8'd5);  put(4, c_op_ldi, 8'h55); put(5, c_op_or, 8'h3C);
    put(6, c_op_and, 8'h0F); put(7, c_op_xor, 8'h0F); put(8, c_op_exit, 8'h00);
    init_dmem(); run_model(); run_dut(0, "brc");
    check_eq("brc:const_out", io_out, 32'h3);
    check_eq("brc:const_carry", io_carry, 32'h1);

    // Illegal opcode acts as NOP
    clear_prog();
    put(0, c_op_ldi, 8'h07); put(1, 8'hEE, 8'h99); put(2, c_op_exit, 8'h00);
    init_dmem(); run_model(); run_dut(0, "illegal");
    check_eq("illegal:const_flag", io_illegal, 32'h1);
    check_eq("illegal:const_out", io_out, 32'h7);

    // Random programs, alternating free-running and paused execution
    for (int t = 0; t < 12; t++) begin
      gen_prog($urandom_range(12, 40));
      init_dmem();
      run_model();
      run_dut(t[0], "rand");
    end

    reset_mid_load();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
